// File: rtl/regfile_scan_reader_pkg.sv
// Shared register-file geometry and scan FSM encoding.
// The geometry constants are also used by the register file, so both stay in step.
package regfile_scan_reader_pkg;

  localparam int RF_NREGS = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

  // Smallest address width able to index n registers (minimum 1 bit).
  function automatic int addr_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

endpackage

// File: rtl/regfile_scan_reader.sv
// Walks the register file through a spare read port and streams (addr, data) words, then an XOR checksum.
// One word per cycle with o_out_valid held stable under backpressure; NREGS+3 cycles start-to-idle with no stalls.
module regfile_scan_reader
  import regfile_scan_reader_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [AW-1:0] o_out_addr,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_last,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_checksum
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  scan_state_e   r_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_out_addr;
  logic [DW-1:0] r_out_data;
  logic [DW-1:0] r_checksum;

  logic w_xfer;
  logic w_last;

  assign w_last = (r_out_addr == LAST_ADDR);
  assign w_xfer = (r_state == ST_SEND) && i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_ptr      <= '0;
            r_checksum <= '0;
            r_state    <= ST_READ;
          end
        end
        ST_READ: begin
          r_out_data <= i_rd_data;
          r_out_addr <= r_ptr;
          r_ptr      <= r_ptr + AW'(1);
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_checksum <= r_checksum ^ r_out_data;
            if (w_last) begin
              // Pointer returns to 0 so the read port idles at address 0.
              r_ptr   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_out_data <= i_rd_data;
              r_out_addr <= r_ptr;
              r_ptr      <= r_ptr + AW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rd_addr   = r_ptr;
  assign o_out_valid = (r_state == ST_SEND);
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;
  assign o_out_last  = w_last;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Scoreboard bench: stimulus pushes expected words and done events, a negedge monitor pops and compares.
module tb_regfile_scan_reader;
  import regfile_scan_reader_pkg::*;

  localparam int NREGS = RF_NREGS;
  localparam int AW    = RF_AW;
  localparam int DW    = RF_DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, out_ready;
  logic          out_valid, out_last, busy, done;
  logic [AW-1:0] rd_addr, out_addr;
  logic [DW-1:0] rd_data, out_data, checksum;

  // Register file model with a synchronous write port and combinational read.
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_dat;
  logic [DW-1:0] rf [NREGS];
  always_ff @(posedge clk) if (wr_en) rf[wr_addr] <= wr_dat;
  assign rd_data = rf[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_scan_reader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_addr(out_addr), .o_out_data(out_data), .o_out_last(out_last),
    .o_busy(busy), .o_done(done), .o_checksum(checksum)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] sum;
  } done_t;

  word_t word_q[$];
  done_t done_q[$];

  // Monitor: compares every transfer and done pulse, and checks stability across stalls.
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin : mon
    word_t w;
    done_t d;
    if (rst !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_addr", 64'(out_addr), 64'(prev_addr));
        check("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (word_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_word: got addr %0d, expected no word", out_addr);
        end else begin
          w = word_q.pop_front();
          check("word_addr", 64'(out_addr), 64'(w.addr));
          check("word_data", 64'(out_data), 64'(w.data));
          check("word_last", 64'(out_last), 64'(w.last));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(d.cyc));
          check("done_checksum", 64'(checksum), 64'(d.sum));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_at(input bit bp, input int k);
    if (!bp) return 1'b1;
    return (k % 4 == 0) || (k % 4 == 3);
  endfunction

  // One full scan; cycle 0 is the cycle in which start is high.
  task automatic scan(input bit bp, input bit wr_test, input bit busy_starts);
    logic [DW-1:0] exp_sum;
    word_t wd;
    done_t dn;
    int k, n, t0, done_rel;
    exp_sum = '0;
    for (int i = 0; i < NREGS; i++) begin
      wd.addr = AW'(i);
      wd.data = (wr_test && i == 20) ? 32'hCAFE_F00D : rf[i];
      wd.last = (i == NREGS - 1);
      exp_sum ^= wd.data;
      word_q.push_back(wd);
    end
    k = 2; n = 0;
    while (n < NREGS) begin
      if (rdy_at(bp, k)) n++;
      k++;
    end
    done_rel = k;
    t0 = cyc;
    dn.cyc = t0 + done_rel;
    dn.sum = exp_sum;
    done_q.push_back(dn);
    start = 1'b1;
    out_ready = rdy_at(bp, 0);
    for (int j = 1; j <= done_rel + 1; j++) begin
      tick();
      start     = busy_starts && (j == 3 || j == 34);
      out_ready = rdy_at(bp, j);
      wr_en     = wr_test && (j == 6 || j == 10);
      wr_addr   = (j == 6) ? AW'(5) : AW'(20);
      wr_dat    = (j == 6) ? 32'hDEAD_BEEF : 32'hCAFE_F00D;
    end
    check("busy_fall", 64'(busy), 64'd0);
    check("words_left", 64'(word_q.size()), 64'd0);
    check("done_left", 64'(done_q.size()), 64'd0);
    start = 1'b0;
    wr_en = 1'b0;
    repeat (5) tick();
    check("checksum_hold", 64'(checksum), 64'(exp_sum));
    check("idle_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_dat = '0;
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);

    for (int i = 0; i < NREGS; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_dat = 32'h1000_0000 + i;
      tick();
    end
    wr_en = 1'b0;
    tick();

    scan(1'b0, 1'b0, 1'b0);   // full dump, no backpressure
    scan(1'b1, 1'b0, 1'b0);   // backpressure 1,0,0,1
    scan(1'b0, 1'b1, 1'b0);   // concurrent writes to R5 and R20
    scan(1'b0, 1'b0, 1'b1);   // start pulses while busy

    // Reset while address 12 is on the output.
    for (int i = 0; i < 12; i++) begin
      word_t wd;
      wd.addr = AW'(i); wd.data = rf[i]; wd.last = 1'b0;
      word_q.push_back(wd);
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (out_valid && out_addr == AW'(12)) found = 1'b1;
      else tick();
    end
    check("midrst_reach12", 64'(found), 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_checksum", 64'(checksum), 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_words_left", 64'(word_q.size()), 64'd0);
    scan(1'b0, 1'b0, 1'b0);

    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rststart_busy", 64'(busy), 64'd0);
    tick();
    check("rststart_busy2", 64'(busy), 64'd0);
    check("rststart_valid", 64'(out_valid), 64'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_scan_reader.md
# regfile_scan_reader

Sequential read-out engine for the 32×32 register file: on a start pulse it walks addresses 0..NREGS-1 through one spare combinational read port and streams each (address, data) pair out over a valid/ready interface, then reports an XOR checksum. It is the reader counterpart to the register file's write port. It sits between the register file and the debug/test output path, so a bench or debug host can dump architectural state without stalling the datapath.

## Interface
- `NREGS`, 32: number of registers scanned, addresses 0..NREGS-1.
- `AW`, 5: address width; NREGS ≤ 2^AW.
- `DW`, 32: data width.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a scan; sampled only in IDLE.
- `rd_addr` output AW: address driven to the register file read port.
- `rd_data` input DW: combinational read data for `rd_addr`.
- `out_valid` output 1: stream word valid.
- `out_ready` input 1: downstream accepts the word.
- `out_addr` output AW: register index of the current word.
- `out_data` output DW: register contents.
- `out_last` output 1: high with the word for address NREGS-1.
- `busy` output 1: scan in progress.
- `done` output 1: one-cycle pulse after the last word transfers.
- `checksum` output DW: XOR of all transferred `out_data`; valid while `done` is high, held until the next `start`.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: `start`=1 → READ. `ptr` cleared to 0 and `checksum` cleared to 0 on that edge.
- READ (1 cycle): `out_data`←`rd_data`, `out_addr`←`ptr`, `ptr`←`ptr`+1 → SEND.
- SEND: `out_valid`=1. `out_data`, `out_addr`, and `out_last` stay stable until a handshake (`out_valid`&&`out_ready`). On a handshake, `checksum` ^= `out_data`.
  - If `out_last`, go to DONE.
  - Otherwise capture `rd_data` at `ptr` in the same edge, advance `ptr`, and stay in SEND. This sustains one word per cycle.
- DONE (1 cycle): `done`=1 → IDLE.
- `rd_addr` = `ptr` at all times. `ptr` is 0 in IDLE.
- `busy` = 1 in READ, SEND and DONE.
- `start` outside IDLE is ignored. It is not queued.
- Each word is a snapshot taken on its capture edge.
  - A register-file write to the same address on that edge is not reflected, because capture sees the pre-write value.
  - Writes to already-captured addresses are never reflected.
  - Writes to not-yet-captured addresses are reflected.
- Address 0 is read like any other register. No forced zero.
- `out_last` = (`out_addr` == NREGS-1).

## Timing
- Reset values: state IDLE, `ptr`=0, `rd_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, `checksum`=0.
- `start` seen at edge of cycle 0:
  - READ in cycle 1.
  - First `out_valid` in cycle 2.
- With `out_ready` held at 1:
  - Words 0..31 transfer in cycles 2..33.
  - `done` is asserted in cycle 34.
  - `busy` falls in cycle 35.
  - Total: NREGS+3 cycles from start to idle.
- Backpressure adds exactly one cycle per cycle that `out_ready`=0 while `out_valid`=1.
- `rst` mid-scan takes effect at the next edge:
  - `out_valid` and `busy` drop.
  - No `done` pulse.
  - `checksum` returns to 0.
- `start` and `rst` asserted together: reset wins.

## Structure
- Shared package holds:
  - the state enum (IDLE/READ/SEND/DONE);
  - localparams for default NREGS/AW/DW;
  - the register-file geometry constants that are shared with the register file itself.
- Single module. The FSM, pointer, output register and checksum are too small to split. No sub-module.

## Test plan
- Reset/idle:
  - Stimulus: hold `rst` 2 cycles, then release with `start`=0 for 10 cycles.
  - Required: all outputs at their reset values; `rd_addr`=0.
- Full dump, no backpressure:
  - Stimulus: preload R[i]=32'h1000_0000+i, pulse `start`, hold `out_ready`=1.
  - Required:
    - 32 words, `out_addr` 0..31 in order, data matching the preload;
    - `out_last` only on address 31;
    - `done` in cycle 34;
    - `checksum`=32'h0000_0000 (XOR of the preload, computed by the bench model).
- Backpressure:
  - Stimulus: `out_ready` toggles 1,0,0,1,….
  - Required:
    - `out_data`/`out_addr` stable whenever `out_valid`=1 and `out_ready`=0;
    - no word lost or duplicated;
    - `done` delayed by the exact number of stall cycles.
- Concurrent writes:
  - Stimulus: during the scan, write R5=32'hDEAD_BEEF on the edge that captures address 5, and write R20=32'hCAFE_F00D before address 20 is captured.
  - Required: word 5 shows its old value; word 20 shows 32'hCAFE_F00D.
- Start while busy:
  - Stimulus: pulse `start` in cycles 3 and 34.
  - Required: both pulses ignored; exactly one scan, one `done` pulse.
- Reset mid-scan:
  - Stimulus: assert `rst` while `out_addr`=12, then `start` again.
  - Required:
    - `out_valid`=0 next cycle, no `done` pulse;
    - the new scan restarts at address 0 with the full 32 words.
